// File: rtl/fp_addsub_param_if.sv
// fp_addsub_param_if
// Bundles the request/response signals of the parametrised floating-point
// adder/subtractor.
//
// Handshake: the requester raises start with oper/a/b valid. The request is
// accepted on a rising clock edge only while ready=1. Once accepted, ready
// stays low until the result edge. At that edge done pulses for exactly one
// cycle, r/flags become valid, and both are held until the next done. A start
// seen while ready=0 is dropped, not queued.
//
// Ports (slave view):
//   start, oper, a, b : in  request
//   r, flags, done    : out result, {invalid, overflow, underflow, inexact}
//   ready             : out can accept a request
//   dbg_state         : out current FSM state encoding
interface fp_addsub_param_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         start;
    logic         oper;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         ready;
    logic         done;
    logic [3:0]   flags;
    logic [2:0]   dbg_state;

    modport master (output start, oper, a, b,
                    input  r, ready, done, flags, dbg_state);
    modport slave  (input  start, oper, a, b,
                    output r, ready, done, flags, dbg_state);
endinterface

// File: rtl/fp_addsub_param.sv
// fp_addsub_param
// Multicycle floating-point adder/subtractor with arbitrary exponent and
// fraction widths. One operation in flight; states IDLE, UNPACK, ALIGN,
// ADDSUB, NORM, ROUND. Denormal inputs are flushed to signed zero.
//
// Optional feature: define FP_ADDSUB_RNE_EN for round-to-nearest-even with
// overflow to signed infinity. Without it the unit truncates and saturates
// overflow to the largest finite magnitude.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : fp_addsub_param_if slave (start/oper/a/b in, r/ready/done/flags out)
module fp_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic            clk,
    input  logic            reset,
    fp_addsub_param_if.slave bus
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int MW  = MAN_W + 4;          // hidden + fraction + G/R/S
    localparam int SW  = MAN_W + 5;          // MW plus carry headroom
    localparam int LZW = $clog2(SW) + 1;
    localparam int XW  = EXP_W + LZW + 2;    // signed working exponent

    localparam logic [EXP_W-1:0]    EXP_ONES = '1;
    localparam logic [W-1:0]        QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [XW-1:0] EXP_MAX = XW'((64'd1 << EXP_W) - 64'd1);
    localparam logic signed [XW-1:0] EXP_ONE = XW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ALIGN  = 3'd2,
        S_ADDSUB = 3'd3,
        S_NORM   = 3'd4,
        S_ROUND  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [W-1:0]           a_q, a_d, b_q, b_d;
    logic                   oper_q, oper_d;
    logic                   sign_q, sign_d;
    logic                   sub_q, sub_d;
    logic signed [XW-1:0]   exp_q, exp_d;
    logic [MW-1:0]          man_l_q, man_l_d;   // larger mantissa, later the normalised result
    logic [MW-1:0]          man_s_q, man_s_d;
    logic [SW-1:0]          sum_q, sum_d;
    logic [W-1:0]           r_q, r_d;
    logic [3:0]             flags_q, flags_d;
    logic                   done_q, done_d;
    logic                   ready_q, ready_d;

    // Operand fields; B's sign is the effective sign after applying oper.
    logic             a_sign, b_esign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign a_sign  = a_q[W-1];
    assign b_esign = b_q[W-1] ^ oper_q;
    assign a_exp   = a_q[W-2:MAN_W];
    assign b_exp   = b_q[W-2:MAN_W];
    assign a_frac  = a_q[MAN_W-1:0];
    assign b_frac  = b_q[MAN_W-1:0];
    assign a_zero  = (a_exp == '0);
    assign b_zero  = (b_exp == '0);
    assign a_inf   = (a_exp == EXP_ONES) && (a_frac == '0);
    assign b_inf   = (b_exp == EXP_ONES) && (b_frac == '0);
    assign a_nan   = (a_exp == EXP_ONES) && (a_frac != '0);
    assign b_nan   = (b_exp == EXP_ONES) && (b_frac != '0);

    // Magnitude ordering and alignment of the smaller operand.
    logic             a_ge_b;
    logic [EXP_W-1:0] exp_big, exp_small, diff;
    logic [MAN_W-1:0] frac_big, frac_small;
    logic [MW-1:0]    m_small, m_shift;
    logic             lost;

    assign a_ge_b     = {a_exp, a_frac} >= {b_exp, b_frac};
    assign exp_big    = a_ge_b ? a_exp  : b_exp;
    assign exp_small  = a_ge_b ? b_exp  : a_exp;
    assign frac_big   = a_ge_b ? a_frac : b_frac;
    assign frac_small = a_ge_b ? b_frac : a_frac;
    assign diff       = exp_big - exp_small;
    assign m_small    = {1'b1, frac_small, 3'b000};

    always_comb begin
        lost    = 1'b0;
        m_shift = m_small >> diff;
        for (int i = 0; i < MW; i++) begin
            if (i < int'(diff)) lost = lost | m_small[i];
        end
        // A shift this large leaves nothing but a nonzero sticky bit.
        if (int'(diff) >= MAN_W + 3) m_shift = {{(MW-1){1'b0}}, 1'b1};
        else                         m_shift[0] = m_shift[0] | lost;
    end

    // Leading-zero count of the non-carry part of the sum.
    logic [LZW-1:0] lzc;
    logic           lz_found;

    always_comb begin
        lzc      = '0;
        lz_found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!lz_found) begin
                if (sum_q[i]) lz_found = 1'b1;
                else          lzc      = lzc + LZW'(1);
            end
        end
    end

    // Rounding of the normalised mantissa held in man_l_q.
    logic                 g_bit, r_bit, s_bit, inexact, rnd_up;
    logic [MAN_W:0]       kept;
    logic [MAN_W+1:0]     rounded;
    logic [MAN_W-1:0]     frac_out;
    logic signed [XW-1:0] exp_r;

    assign g_bit   = man_l_q[2];
    assign r_bit   = man_l_q[1];
    assign s_bit   = man_l_q[0];
    assign kept    = man_l_q[MW-1:3];
    assign inexact = g_bit | r_bit | s_bit;
`ifdef FP_ADDSUB_RNE_EN
    assign rnd_up  = g_bit & (r_bit | s_bit | kept[0]);
`else
    assign rnd_up  = 1'b0;
`endif
    assign rounded  = {1'b0, kept} + {{(MAN_W+1){1'b0}}, rnd_up};
    assign frac_out = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    assign exp_r    = rounded[MAN_W+1] ? exp_q + EXP_ONE : exp_q;

    logic [SW-1:0] sum_c;
    logic          finish;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        oper_d  = oper_q;
        sign_d  = sign_q;
        sub_d   = sub_q;
        exp_d   = exp_q;
        man_l_d = man_l_q;
        man_s_d = man_s_q;
        sum_d   = sum_q;
        r_d     = r_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        ready_d = ready_q;
        finish  = 1'b0;
        sum_c   = sub_q ? ({1'b0, man_l_q} - {1'b0, man_s_q})
                        : ({1'b0, man_l_q} + {1'b0, man_s_q});

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    oper_d  = bus.oper;
                    ready_d = 1'b0;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                finish  = 1'b1;
                flags_d = 4'b0000;
                if (a_nan || b_nan) begin
                    r_d = QNAN;
                end else if (a_inf && b_inf) begin
                    if (a_sign != b_esign) begin
                        r_d     = QNAN;
                        flags_d = 4'b1000;
                    end else begin
                        r_d = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
                    end
                end else if (a_inf) begin
                    r_d = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
                end else if (b_inf) begin
                    r_d = {b_esign, EXP_ONES, {MAN_W{1'b0}}};
                end else if (a_zero && b_zero) begin
                    r_d = {a_sign & b_esign, {(W-1){1'b0}}};
                end else if (a_zero) begin
                    r_d = {b_esign, b_exp, b_frac};
                end else if (b_zero) begin
                    r_d = a_q;
                end else begin
                    finish  = 1'b0;
                    flags_d = flags_q;
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                sign_d  = a_ge_b ? a_sign : b_esign;
                sub_d   = a_sign ^ b_esign;
                exp_d   = $signed({{(XW-EXP_W){1'b0}}, exp_big});
                man_l_d = {1'b1, frac_big, 3'b000};
                man_s_d = m_shift;
                state_d = S_ADDSUB;
            end
            S_ADDSUB: begin
                sum_d = sum_c;
                if (sum_c == '0) begin
                    r_d     = '0;
                    flags_d = 4'b0000;
                    finish  = 1'b1;
                end else begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (sum_q[SW-1]) begin
                    // Keep the bit shifted out in sticky.
                    man_l_d = {sum_q[SW-1:2], sum_q[1] | sum_q[0]};
                    exp_d   = exp_q + EXP_ONE;
                end else begin
                    man_l_d = sum_q[MW-1:0] << lzc;
                    exp_d   = exp_q - $signed({{(XW-LZW){1'b0}}, lzc});
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                finish = 1'b1;
                if (exp_q[XW-1] || exp_q == '0) begin
                    r_d     = {sign_q, {(W-1){1'b0}}};
                    flags_d = 4'b0011;
                end else if (exp_r >= EXP_MAX) begin
`ifdef FP_ADDSUB_RNE_EN
                    r_d = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
`else
                    r_d = {sign_q, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}};
`endif
                    flags_d = 4'b0101;
                end else begin
                    r_d     = {sign_q, exp_r[EXP_W-1:0], frac_out};
                    flags_d = {3'b000, inexact};
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase

        if (finish) begin
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            oper_q  <= 1'b0;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            exp_q   <= '0;
            man_l_q <= '0;
            man_s_q <= '0;
            sum_q   <= '0;
            r_q     <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            oper_q  <= oper_d;
            sign_q  <= sign_d;
            sub_q   <= sub_d;
            exp_q   <= exp_d;
            man_l_q <= man_l_d;
            man_s_q <= man_s_d;
            sum_q   <= sum_d;
            r_q     <= r_d;
            flags_q <= flags_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign bus.r         = r_q;
    assign bus.flags     = flags_q;
    assign bus.done      = done_q;
    assign bus.ready     = ready_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_fp_addsub_param.sv
// tb_fp_addsub_param
// Directed bench for fp_addsub_param in single-precision configuration.
// Expected results are hand-computed IEEE-754 encodings; rounding-dependent
// expectations follow FP_ADDSUB_RNE_EN.
module tb_fp_addsub_param;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

`ifdef FP_ADDSUB_RNE_EN
    localparam logic [31:0] EXP_RND_UP = 32'h3F800001;
    localparam logic [31:0] EXP_OVF    = 32'h7F800000;
`else
    localparam logic [31:0] EXP_RND_UP = 32'h3F800000;
    localparam logic [31:0] EXP_OVF    = 32'h7F7FFFFF;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_fail = 0;

    fp_addsub_param_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_addsub_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "global time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble the inputs after acceptance, and return the
    // number of edges from the accept edge to the done edge (99 on timeout).
    task automatic run_op(input logic op, input logic [31:0] av, input logic [31:0] bv,
                          output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bus.start = 1'b1;
        bus.oper  = op;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.oper  = ~op;
        bus.a     = $urandom();
        bus.b     = $urandom();
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.done && lat < 20);
        if (!bus.done) lat = 99;
    endtask

    task automatic do_vec(input string tag, input logic op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp_r,
                          input logic [3:0] exp_f, input int exp_lat);
        int lat;
        run_op(op, av, bv, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_r"}, bus.r, exp_r);
        check({tag, "_flags"}, bus.flags, exp_f);
    endtask

    initial begin
        int lat;
        int cnt;
        int e1, e2, edge_n;

        bus.start = 1'b0;
        bus.oper  = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", bus.ready, 1);
        check("rst_r", bus.r, 0);
        check("rst_done", bus.done, 0);
        check("rst_flags", bus.flags, 0);
        reset = 1'b1;

        // Normal path, five edges.
        do_vec("sub_24_2",    1'b1, 32'h41C00000, 32'h40000000, 32'h41B00000, 4'h0, 5);
        do_vec("sub_lzc2",    1'b1, 32'h40A00000, 32'h40800000, 32'h3F800000, 4'h0, 5);
        do_vec("add_1_1",     1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'h0, 5);
        do_vec("add_mixsign", 1'b0, 32'h40400000, 32'hBF800000, 32'h40000000, 4'h0, 5);
        do_vec("sub_neg",     1'b1, 32'h3F800000, 32'h40400000, 32'hC0000000, 4'h0, 5);
        do_vec("round_gr",    1'b0, 32'h3F800000, 32'h33C00000, EXP_RND_UP,   4'h1, 5);
        do_vec("round_tie",   1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'h1, 5);
        do_vec("sticky_only", 1'b0, 32'h3F800000, 32'h2B800000, 32'h3F800000, 4'h1, 5);
        do_vec("overflow",    1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, EXP_OVF,      4'h5, 5);
        do_vec("underflow",   1'b1, 32'h00800000, 32'h00C00000, 32'h80000000, 4'h3, 5);
        // Exact cancellation, three edges.
        do_vec("cancel",      1'b1, 32'h40800000, 32'h40800000, 32'h00000000, 4'h0, 3);
        // Special and zero-operand paths, one edge.
        do_vec("inf_m_inf",   1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'h8, 1);
        do_vec("nan_in",      1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'h0, 1);
        do_vec("zero_m_2",    1'b1, 32'h00000000, 32'h40000000, 32'hC0000000, 4'h0, 1);
        do_vec("negz_negz",   1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 4'h0, 1);
        do_vec("fin_m_inf",   1'b1, 32'h3F800000, 32'h7F800000, 32'hFF800000, 4'h0, 1);

        // Reset while the operation sits in ALIGN: abort, no done.
        @(negedge clk);
        bus.start = 1'b1;
        bus.oper  = 1'b1;
        bus.a     = 32'h41C00000;
        bus.b     = 32'h40000000;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ready", bus.ready, 1);
        check("abort_r", bus.r, 0);
        check("abort_flags", bus.flags, 0);
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.done) cnt++;
        end
        check("abort_no_done", cnt, 0);

        // Start while busy is dropped; the in-flight operands are used.
        @(negedge clk);
        bus.start = 1'b1;
        bus.oper  = 1'b0;
        bus.a     = 32'h3F800000;
        bus.b     = 32'h3F800000;
        @(posedge clk);
        @(negedge clk);
        bus.oper  = 1'b1;
        bus.a     = 32'h40A00000;
        bus.b     = 32'h40800000;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("busy_lat", lat, 5);
        check("busy_r", bus.r, 32'h40000000);
        cnt = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.done) cnt++;
        end
        check("busy_not_queued", cnt, 0);
        do_vec("after_busy", 1'b1, 32'h40A00000, 32'h40800000, 32'h3F800000, 4'h0, 5);

        // start held high: the next accept waits one ready cycle after done.
        @(negedge clk);
        bus.start = 1'b1;
        bus.oper  = 1'b0;
        bus.a     = 32'h3F800000;
        bus.b     = 32'h3F800000;
        @(posedge clk);
        e1 = 0;
        e2 = 0;
        edge_n = 0;
        while (e2 == 0 && edge_n < 40) begin
            @(posedge clk);
            #1;
            edge_n++;
            if (bus.done) begin
                if (e1 == 0) e1 = edge_n;
                else         e2 = edge_n;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("held_first", e1, 5);
        check("held_gap", e2 - e1, 6);
        repeat (8) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
